// File: rtl/squarer_pkg.sv
// Shared widths, result record and saturating-add helper for the squarer stream.
package squarer_pkg;
  localparam int A_W    = 4;
  localparam int Y_W    = 8;
  localparam int G_W    = 32;
  localparam int ONES_W = 7;

  typedef struct packed {
    logic [Y_W-1:0]    y;
    logic [ONES_W-1:0] gones;
    logic              err;
  } sq_result_t;

  // Adds inc to cnt and clamps at max_val; cnt is assumed already <= max_val.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] w_sum;
    w_sum = {1'b0, cnt} + {1'b0, inc};
    return (w_sum > {1'b0, max_val}) ? max_val : w_sum[31:0];
  endfunction
endpackage

// File: rtl/garbage_popcount.sv
// Combinational population count across both 32-bit garbage buses.
module garbage_popcount
  import squarer_pkg::*;
(
  input  logic [G_W-1:0]    garbage_pp,
  input  logic [G_W-1:0]    garbage_sum,
  output logic [ONES_W-1:0] ones
);
  logic [5:0] w_cnt_pp;
  logic [5:0] w_cnt_sum;

  always_comb begin
    w_cnt_pp  = '0;
    w_cnt_sum = '0;
    for (int i = 0; i < G_W; i++) begin
      w_cnt_pp  = w_cnt_pp  + 6'(garbage_pp[i]);
      w_cnt_sum = w_cnt_sum + 6'(garbage_sum[i]);
    end
  end

  assign ones = 7'(w_cnt_pp) + 7'(w_cnt_sum);
endmodule

// File: rtl/squarer_4bit.sv
// Combinational 4-bit reversible squarer: square plus the partial-product
// and adder-chain garbage lines that the reversible mapping leaves behind.
module squarer_4bit (
  input  logic [3:0]  a,
  output logic [7:0]  y,
  output logic [31:0] garbage_pp,
  output logic [31:0] garbage_sum
);
  logic [7:0] w_r0, w_r1, w_r2, w_r3;
  logic [7:0] w_s1, w_s2;

  assign w_r0 = a[0] ? {4'b0, a}       : 8'd0;
  assign w_r1 = a[1] ? {3'b0, a, 1'b0} : 8'd0;
  assign w_r2 = a[2] ? {2'b0, a, 2'b0} : 8'd0;
  assign w_r3 = a[3] ? {1'b0, a, 3'b0} : 8'd0;

  assign w_s1 = w_r0 + w_r1;
  assign w_s2 = w_s1 + w_r2;
  assign y    = w_s2 + w_r3;

  // Low half: every a[i]&a[j] Toffoli target; high half: input copies on the control lines.
  always_comb begin
    garbage_pp = {{4{a}}, 16'd0};
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        garbage_pp[i*4+j] = a[i] & a[j];
      end
    end
  end

  assign garbage_sum = {w_r3, w_r2, w_s2, w_s1};
endmodule

// File: rtl/squarer_stream.sv
// Valid/ready wrapper around squarer_4bit: two-stage pipe, registered results
// with garbage popcount and self-check, plus saturating statistics counters.
module squarer_stream
  import squarer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [A_W-1:0]    in_a,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Y_W-1:0]    out_y,
  output logic [ONES_W-1:0] out_gones,
  output logic              out_err,
  input  logic              clear_stats,
  output logic [CNT_W-1:0]  stat_count,
  output logic [CNT_W-1:0]  stat_gones,
  output logic [CNT_W-1:0]  stat_err
);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  logic              r_vld_p1;
  logic [A_W-1:0]    r_a_p1;
  logic              r_vld_p2;
  sq_result_t        r_res_p2;
  logic              w_s2_ready;
  logic              w_out_hs;
  logic [Y_W-1:0]    w_y;
  logic [Y_W-1:0]    w_ref;
  logic [G_W-1:0]    w_gpp;
  logic [G_W-1:0]    w_gsum;
  logic [ONES_W-1:0] w_ones;
  sq_result_t        w_res;
  logic [CNT_W-1:0]  r_stat_count;
  logic [CNT_W-1:0]  r_stat_gones;
  logic [CNT_W-1:0]  r_stat_err;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_s2_ready = !r_vld_p2 || out_ready;
  assign in_ready   = w_rst_n && (!r_vld_p1 || w_s2_ready);
  assign w_out_hs   = r_vld_p2 && out_ready;

  // S1: operand register
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_vld_p1 <= 1'b0;
      r_a_p1   <= '0;
    end else if (in_ready) begin
      r_vld_p1 <= in_valid;
      if (in_valid) r_a_p1 <= in_a;
    end
  end

  squarer_4bit u_sq (
    .a           (r_a_p1),
    .y           (w_y),
    .garbage_pp  (w_gpp),
    .garbage_sum (w_gsum)
  );

  garbage_popcount u_pop (
    .garbage_pp  (w_gpp),
    .garbage_sum (w_gsum),
    .ones        (w_ones)
  );

  assign w_ref       = {4'b0, r_a_p1} * {4'b0, r_a_p1};
  assign w_res.y     = w_y;
  assign w_res.gones = w_ones;
  assign w_res.err   = (w_y != w_ref);

  // S2: result register
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_vld_p2 <= 1'b0;
      r_res_p2 <= '0;
    end else if (w_s2_ready) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_res_p2 <= w_res;
    end
  end

  assign out_valid = r_vld_p2;
  assign out_y     = r_res_p2.y;
  assign out_gones = r_res_p2.gones;
  assign out_err   = r_res_p2.err;

  // Clear has priority over a coincident handshake.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_stat_count <= '0;
      r_stat_gones <= '0;
      r_stat_err   <= '0;
    end else if (clear_stats) begin
      r_stat_count <= '0;
      r_stat_gones <= '0;
      r_stat_err   <= '0;
    end else if (w_out_hs) begin
      r_stat_count <= CNT_W'(sat_add(32'(r_stat_count), 32'd1, CNT_MAX));
      r_stat_gones <= CNT_W'(sat_add(32'(r_stat_gones), 32'(r_res_p2.gones), CNT_MAX));
      r_stat_err   <= CNT_W'(sat_add(32'(r_stat_err), 32'(r_res_p2.err), CNT_MAX));
    end
  end

  assign stat_count = r_stat_count;
  assign stat_gones = r_stat_gones;
  assign stat_err   = r_stat_err;
endmodule

// File: tb/tb_squarer_stream.sv
// Directed bench for squarer_stream: table of hand-computed squares/popcounts,
// a negedge scoreboard, and short sequences for clear, saturation and reset.
module tb_squarer_stream;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_a;
  logic       out_ready;
  logic       clear_stats;

  logic        in_ready, out_valid, out_err;
  logic [7:0]  out_y;
  logic [6:0]  out_gones;
  logic [15:0] stat_count, stat_gones, stat_err;

  logic       s4_in_ready, s4_valid, s4_err;
  logic [7:0] s4_y;
  logic [6:0] s4_gones;
  logic [3:0] s4_count, s4_sgones, s4_serr;

  squarer_stream #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_gones(out_gones),
    .out_err(out_err), .clear_stats(clear_stats), .stat_count(stat_count),
    .stat_gones(stat_gones), .stat_err(stat_err)
  );

  squarer_stream #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s4_in_ready), .in_a(in_a),
    .out_valid(s4_valid), .out_ready(out_ready), .out_y(s4_y), .out_gones(s4_gones),
    .out_err(s4_err), .clear_stats(clear_stats), .stat_count(s4_count),
    .stat_gones(s4_sgones), .stat_err(s4_serr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] y;
    logic [6:0] g;
  } vec_t;
  vec_t tbl[16];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 0;
  bit lat_arm = 0;
  int first_in, first_out, last_out, n_out;
  logic [3:0] q[$];
  logic [3:0] exp_a;
  bit prev_stall = 0;
  logic [7:0] prev_y;
  logic [6:0] prev_g;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard, mid-cycle sampling
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_valid && in_ready) begin
        q.push_back(in_a);
        check("s4_in_ready", 32'(s4_in_ready), 32'd1);
        if (lat_arm && first_in < 0) first_in = cyc;
      end
      if (!in_ready)
        check("in_ready_low_only_when_full", 32'(out_valid && !out_ready), 32'd1);
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_y", 32'(out_y), 32'(prev_y));
        check("hold_gones", 32'(out_gones), 32'(prev_g));
      end
      if (out_valid && out_ready) begin
        check("out_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_a = q.pop_front();
          check("out_y", 32'(out_y), 32'(tbl[exp_a].y));
          check("out_gones", 32'(out_gones), 32'(tbl[exp_a].g));
          check("out_err", 32'(out_err), 32'd0);
          check("s4_valid", 32'(s4_valid), 32'd1);
          check("s4_y", 32'(s4_y), 32'(tbl[exp_a].y));
          check("s4_gones", 32'(s4_gones), 32'(tbl[exp_a].g));
          check("s4_err", 32'(s4_err), 32'd0);
        end
        n_out++;
        if (lat_arm && first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_y = out_y;
      prev_g = out_gones;
    end
  end

  task automatic stream(input int n, input bit rnd);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 2000) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_a      = tbl[idx % 16].a;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_ready) idx++;
      guard++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (guard >= 2000) check("stream_timeout", 32'(idx), 32'(n));
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_stats = 1'b1;
    @(posedge clk); #1 clear_stats = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'd0,  8'd0,   7'd0};
    tbl[1]  = '{4'd1,  8'd1,   7'd7};
    tbl[2]  = '{4'd2,  8'd4,   7'd7};
    tbl[3]  = '{4'd3,  8'd9,   7'd16};
    tbl[4]  = '{4'd4,  8'd16,  7'd7};
    tbl[5]  = '{4'd5,  8'd25,  7'd19};
    tbl[6]  = '{4'd6,  8'd36,  7'd18};
    tbl[7]  = '{4'd7,  8'd49,  7'd30};
    tbl[8]  = '{4'd8,  8'd64,  7'd6};
    tbl[9]  = '{4'd9,  8'd81,  7'd18};
    tbl[10] = '{4'd10, 8'd100, 7'd18};
    tbl[11] = '{4'd11, 8'd121, 7'd28};
    tbl[12] = '{4'd12, 8'd144, 7'd18};
    tbl[13] = '{4'd13, 8'd169, 7'd32};
    tbl[14] = '{4'd14, 8'd196, 7'd33};
    tbl[15] = '{4'd15, 8'd225, 7'd48};

    rst_n = 1'b0; in_valid = 1'b0; in_a = 4'd0; out_ready = 1'b1; clear_stats = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    check("rst_out_gones", 32'(out_gones), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_stat_count", 32'(stat_count), 32'd0);
    check("rst_stat_gones", 32'(stat_gones), 32'd0);
    check("rst_stat_err", 32'(stat_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rdy_after_rst", 32'(in_ready), 32'd1);
    mon_en = 1;

    // Back-to-back 0..15
    first_in = -1; first_out = -1; last_out = -1; n_out = 0; lat_arm = 1;
    stream(16, 1'b0);
    drain();
    lat_arm = 0;
    check("latency", 32'(first_out - first_in), 32'd2);
    check("throughput_span", 32'(last_out - first_out), 32'd15);
    check("b2b_n_out", 32'(n_out), 32'd16);
    check("b2b_stat_count", 32'(stat_count), 32'd16);
    check("b2b_stat_gones", 32'(stat_gones), 32'd305);
    check("b2b_stat_err", 32'(stat_err), 32'd0);
    check("sat4_count_16", 32'(s4_count), 32'd15);
    check("sat4_gones_16", 32'(s4_sgones), 32'd15);

    // Random stalls, two passes
    pulse_clear();
    @(negedge clk);
    check("clr_stat_count", 32'(stat_count), 32'd0);
    n_out = 0;
    stream(32, 1'b1);
    drain();
    check("rnd_n_out", 32'(n_out), 32'd32);
    check("rnd_stat_count", 32'(stat_count), 32'd32);
    check("rnd_stat_gones", 32'(stat_gones), 32'd610);
    check("rnd_stat_err", 32'(stat_err), 32'd0);

    // Clear coincident with a handshake
    @(posedge clk); #1 in_valid = 1'b1; in_a = 4'd3; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 clear_stats = 1'b1;
    @(negedge clk);
    check("clr_hs_valid", 32'(out_valid && out_ready), 32'd1);
    @(posedge clk); #1 clear_stats = 1'b0;
    @(negedge clk);
    check("clr_hs_count", 32'(stat_count), 32'd0);
    check("clr_hs_gones", 32'(stat_gones), 32'd0);
    check("clr_hs_err", 32'(stat_err), 32'd0);
    @(posedge clk); #1 in_valid = 1'b1; in_a = 4'd5;
    @(posedge clk); #1 in_valid = 1'b0;
    drain();
    check("after_clr_count", 32'(stat_count), 32'd1);
    check("after_clr_gones", 32'(stat_gones), 32'd19);
    check("after_clr_s4_count", 32'(s4_count), 32'd1);
    check("after_clr_s4_gones", 32'(s4_sgones), 32'd15);

    // Saturation with 20 results
    pulse_clear();
    stream(20, 1'b0);
    drain();
    check("sat20_count16", 32'(stat_count), 32'd20);
    check("sat20_gones16", 32'(stat_gones), 32'd335);
    check("sat20_count4", 32'(s4_count), 32'd15);
    check("sat20_gones4", 32'(s4_sgones), 32'd15);
    check("sat20_err4", 32'(s4_serr), 32'd0);

    // Reset with both stages full (9 in S2, 10 in S1)
    @(posedge clk); #1 in_valid = 1'b1; in_a = 4'd9; out_ready = 1'b0;
    @(posedge clk); #1 in_a = 4'd10;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("full_out_y", 32'(out_y), 32'd81);
    check("full_in_ready", 32'(in_ready), 32'd0);
    #2;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_y", 32'(out_y), 32'd0);
    check("mid_rst_gones", 32'(out_gones), 32'd0);
    check("mid_rst_err", 32'(out_err), 32'd0);
    check("mid_rst_count", 32'(stat_count), 32'd0);
    q.delete();
    prev_stall = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    out_ready = 1'b1;
    n_out = 0;
    mon_en = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("no_ghost_out", 32'(n_out), 32'd0);
    @(posedge clk); #1 in_valid = 1'b1; in_a = 4'd6;
    @(posedge clk); #1 in_valid = 1'b0;
    drain();
    check("post_rst_n_out", 32'(n_out), 32'd1);
    check("post_rst_count", 32'(stat_count), 32'd1);
    check("post_rst_gones", 32'(stat_gones), 32'd18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
